// File: rtl/agrupate_mc_if.sv
// Stream bundle for the result grouper: scalar results in, packed groups out.
// master drives results and downstream ready; slave is the grouper itself.
interface agrupate_mc_if #(
  parameter int GROUP_SIZE = 4,
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]            data_in;
  logic [GROUP_SIZE-1:0]            mask_in;
  logic                             valid_in;
  logic                             avail_out;
  logic [GROUP_SIZE*DATA_WIDTH-1:0] data_out;
  logic [GROUP_SIZE-1:0]            mask_out;
  logic                             valid_out;
  logic                             avail_in;

  modport master (
    output data_in, mask_in, valid_in, avail_in,
    input  avail_out, data_out, mask_out, valid_out
  );

  modport slave (
    input  data_in, mask_in, valid_in, avail_in,
    output avail_out, data_out, mask_out, valid_out
  );
endinterface

// File: rtl/agrupate_mc.sv
// Result grouper: buffers masked scalar results in a small FIFO, merges them
// into groups of active slots and emits each group through a holding register.
module agrupate_mc #(
  parameter int GROUP_SIZE     = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int LOG_FIFO_DEPTH = 2,
  parameter int LOG_MAX_GROUPS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      configure,
  input  logic [LOG_MAX_GROUPS-1:0] cfg_num_groups,
  input  logic [GROUP_SIZE-1:0]     cfg_active_mask,
  input  logic                      flush,
  agrupate_mc_if.slave              bus,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow_err,
  output logic                      collision_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  localparam logic [LOG_FIFO_DEPTH:0] DEPTH_C = (LOG_FIFO_DEPTH+1)'(FIFO_DEPTH);

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0]     fifo_data [FIFO_DEPTH];
  logic [GROUP_SIZE-1:0]     fifo_mask [FIFO_DEPTH];
  logic [LOG_FIFO_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [LOG_FIFO_DEPTH:0]   count, free_cnt;
  logic                      full, empty, wr_en;

  logic [DATA_WIDTH-1:0]     acc [GROUP_SIZE];
  logic [DATA_WIDTH-1:0]     acc_d [GROUP_SIZE];
  logic [GROUP_SIZE-1:0]     filled, filled_d, active_mask, m, merge_mask, emit_mask;
  logic [LOG_MAX_GROUPS-1:0] grp_cnt;
  logic                      bounded, grp_left, out_free, pop, emit, coll_set;

  logic [GROUP_SIZE*DATA_WIDTH-1:0] group_d, group_p1;
  logic [GROUP_SIZE-1:0]            mask_p1;
  logic                             vld_p1;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign free_cnt = DEPTH_C - count;
  // Full is judged before any pop in the same cycle, so a write into a full FIFO drops.
  assign wr_en    = rst & ~configure & bus.valid_in & ~full;

  assign bus.avail_out = rst & (free_cnt >= (LOG_FIFO_DEPTH+1)'(2));
  assign bus.data_out  = group_p1;
  assign bus.mask_out  = mask_p1;
  assign bus.valid_out = vld_p1;
  assign busy          = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign done          = (state_q == S_DONE);

  assign out_free   = ~vld_p1 | bus.avail_in;
  assign grp_left   = ~bounded | (grp_cnt != '0);
  assign m          = fifo_mask[rd_ptr] & active_mask;
  assign merge_mask = filled | m;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    emit      = 1'b0;
    emit_mask = '0;
    coll_set  = 1'b0;
    filled_d  = filled;
    acc_d     = acc;
    case (state_q)
      S_RUN, S_FLUSH: begin
        if (!empty && out_free && grp_left) begin
          pop = 1'b1;
          for (int i = 0; i < GROUP_SIZE; i++)
            if (m[i]) acc_d[i] = fifo_data[rd_ptr];
          coll_set = |(filled & m);
          if (merge_mask == active_mask && active_mask != '0) begin
            emit      = 1'b1;
            emit_mask = active_mask;
            filled_d  = '0;
          end else begin
            filled_d  = merge_mask;
          end
        end else if (state_q == S_FLUSH && empty && out_free) begin
          if (filled != '0 && grp_left) begin
            emit      = 1'b1;
            emit_mask = filled;
            filled_d  = '0;
          end
          state_d = S_RUN;
        end
        if (state_q == S_RUN && flush) state_d = S_FLUSH;
        // Once the counter is exhausted no further emit can occur, so this transfer is the last.
        if (bounded && grp_cnt == '0 && vld_p1 && bus.avail_in) state_d = S_DONE;
      end
      default: ;
    endcase
    if (configure) begin
      state_d  = S_RUN;
      pop      = 1'b0;
      emit     = 1'b0;
      coll_set = 1'b0;
    end
  end

  always_comb begin
    group_d = '0;
    for (int i = 0; i < GROUP_SIZE; i++)
      group_d[i*DATA_WIDTH +: DATA_WIDTH] = emit_mask[i] ? acc_d[i] : '0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_data[wr_ptr] <= bus.data_in;
      fifo_mask[wr_ptr] <= bus.mask_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      filled        <= '0;
      active_mask   <= '0;
      grp_cnt       <= '0;
      bounded       <= 1'b0;
      overflow_err  <= 1'b0;
      collision_err <= 1'b0;
      vld_p1        <= 1'b0;
      group_p1      <= '0;
      mask_p1       <= '0;
      for (int i = 0; i < GROUP_SIZE; i++) acc[i] <= '0;
    end else if (configure) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      filled        <= '0;
      active_mask   <= cfg_active_mask;
      grp_cnt       <= cfg_num_groups;
      bounded       <= (cfg_num_groups != '0);
      overflow_err  <= 1'b0;
      collision_err <= 1'b0;
      vld_p1        <= 1'b0;
      group_p1      <= '0;
      mask_p1       <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count  <= count + {{LOG_FIFO_DEPTH{1'b0}}, wr_en} - {{LOG_FIFO_DEPTH{1'b0}}, pop};
      filled <= filled_d;
      acc    <= acc_d;
      if (bus.valid_in && full) overflow_err  <= 1'b1;
      if (coll_set)             collision_err <= 1'b1;
      // Output stage: load a new group or retire the held one on transfer.
      if (emit) begin
        vld_p1   <= 1'b1;
        group_p1 <= group_d;
        mask_p1  <= emit_mask;
        if (bounded) grp_cnt <= grp_cnt - LOG_MAX_GROUPS'(1);
      end else if (bus.avail_in) begin
        vld_p1   <= 1'b0;
      end
    end
  end

endmodule
